operand_entry: RTL and testbench
================================

Name: operand_entry

Overview:
- Input stage of the calculator; sits directly upstream of the ALU and the 7-segment display driver.
- Synchronises and debounces the two active-low push-buttons and the active-low operand switches, and latches operand A and operand B.
- Sequences entry through a small state machine and drives the status LEDs.
- Provides the ALU with the two operands plus a valid flag, and provides the display with the value to show.

Parameters:
- W, 4, operand width in bits (switch count).
- DEBOUNCE_CYCLES, 250000, number of consecutive stable clk cycles required before a key level is accepted (5 ms at 50 MHz); minimum value 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- in_number  input  W  operand switches, active-low.
- key  input  2  push-buttons, active-low; key[0] loads A, key[1] loads B.
- reg_1  output  W  operand A to the ALU.
- reg_2  output  W  operand B to the ALU.
- ind  output  W  most recently loaded operand, to the display.
- led  output  3  status LEDs, active-low.
- operands_valid  output  1  high while both A and B hold loaded values.
- load_pulse  output  1  one-cycle strobe on every A or B load.

Behaviour:
- Reset:
  - Applied on any clk edge with rst=1; takes priority over everything and may be asserted mid-debounce or mid-sequence.
  - reg_1=0, reg_2=0, ind=0, led=3'b110, operands_valid=0, load_pulse=0, state=EMPTY.
  - Debounce counters are cleared; stable key levels are set to 1 (released); synchronisers are set to all-ones.
- Synchronisation: key and in_number each pass through a 2-FF synchroniser. Loaded operand value = bitwise NOT of the synchronised in_number.
- Debounce, per key:
  - Counter clears whenever the synchronised level equals the stable level.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the stable level takes the synchronised level and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles produces no change.
- Press event: stable level goes 1->0 (registered edge detect). Release produces no event.
- Latency: press event detected in cycle N; reg_x, ind, led, state and load_pulse update at the edge ending cycle N. Total from raw key edge = 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
- States and led codes:
  - EMPTY = 110.
  - HAVE_A = 101.
  - HAVE_B = 011.
  - READY = 001.
- Transitions on a single A press (B press is symmetric, using reg_2):
  - reg_1 and ind take the operand; load_pulse=1.
  - EMPTY->HAVE_A; HAVE_B->READY; HAVE_A->HAVE_A (overwrite); READY->READY (overwrite).
- Simultaneous A and B press events in the same cycle:
  - Clear: reg_1=reg_2=ind=0, state=EMPTY, load_pulse=0.
  - Held both keys with staggered debounce completion are two separate presses, not a clear.
- Outputs:
  - operands_valid = (state==READY), registered.
  - load_pulse is high for exactly one cycle per load; never high on a clear or during reset.
- Switch changes without a key press never alter any output.

Decomposition:
- Shared package operand_entry_pkg:
  - State enum {EMPTY, HAVE_A, HAVE_B, READY}.
  - LED code constants LED_EMPTY, LED_HAVE_A, LED_HAVE_B, LED_READY.
  - Default DEBOUNCE_CYCLES.
- Sub-module key_debounce: 2-FF synchroniser, counter and stable register, with a press-event output. Instantiated once per key. Parameter DEBOUNCE_CYCLES; ports clk, rst, key_n, stable, press.
- Top level holds the in_number synchroniser, the FSM and the operand registers.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset: rst high 2 cycles with keys released -> reg_1=reg_2=ind=0, led=110, operands_valid=0, load_pulse=0.
- Load A: in_number=4'b1010, key=2'b10 held 10 cycles -> exactly 7 cycles after the key edge: reg_1=4'h5, ind=4'h5, led=101, one load_pulse. Then load B: in_number=4'b0011, key=2'b01 -> reg_2=4'hC, ind=4'hC, led=001, operands_valid=1.
- Bounce: key[0] toggled low/high every 2 cycles for 20 cycles, then released -> no load_pulse, state unchanged.
- Simultaneous: from READY, key=2'b00 asserted in the same cycle -> reg_1=reg_2=ind=0, led=110, operands_valid=0, no load_pulse.
- Overwrite: in READY, press A with in_number=4'b0000 -> reg_1=4'hF, state stays READY, operands_valid stays 1.
- Reset mid-debounce: key[0] low for 3 cycles, rst pulsed, key held low afterwards -> no load until a full 2+4+1 cycles after the reset release, then a single load.

Source files
------------

// File: rtl/operand_entry_pkg.sv
// Shared state encoding, LED codes and defaults for the calculator operand entry stage.
package operand_entry_pkg;

   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      HAVE_A = 2'd1,
      HAVE_B = 2'd2,
      READY  = 2'd3
   } state_e;

   // LEDs are active-low
   localparam logic [2:0] LED_EMPTY  = 3'b110;
   localparam logic [2:0] LED_HAVE_A = 3'b101;
   localparam logic [2:0] LED_HAVE_B = 3'b011;
   localparam logic [2:0] LED_READY  = 3'b001;

   localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 250000;

   function automatic logic [2:0] state_led(input state_e s);
      logic [2:0] code;
      code = LED_EMPTY;
      case (s)
         EMPTY:   code = LED_EMPTY;
         HAVE_A:  code = LED_HAVE_A;
         HAVE_B:  code = LED_HAVE_B;
         READY:   code = LED_READY;
         default: code = LED_EMPTY;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/operand_entry_key_debounce.sv
// Active-low push-button conditioner: 2-FF synchroniser, stability counter,
// accepted (stable) level and a one-cycle press event on each 1->0 of that level.
module key_debounce
   import operand_entry_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic key_n,
   output logic stable,
   output logic press
);

   localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;
   logic          stable_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync     <= '1;
         cnt      <= '0;
         stable   <= 1'b1;
         stable_q <= 1'b1;
      end else begin
         sync     <= {sync[0], key_n};
         stable_q <= stable;
         // Any cycle agreeing with the accepted level restarts the count
         if (sync[1] == stable) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            stable <= sync[1];
            cnt    <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign press = stable_q & ~stable;

endmodule

// File: rtl/operand_entry.sv
// Calculator input stage: debounced keys load operands A/B from the active-low
// switches, sequence EMPTY/HAVE_A/HAVE_B/READY and drive status LEDs.
module operand_entry
   import operand_entry_pkg::*;
#(
   parameter int unsigned W               = 4,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] in_number,
   input  logic [1:0]   key,
   output logic [W-1:0] reg_1,
   output logic [W-1:0] reg_2,
   output logic [W-1:0] ind,
   output logic [2:0]   led,
   output logic         operands_valid,
   output logic         load_pulse
);

   logic [W-1:0] num_s1, num_s2, operand;
   logic [1:0]   key_press;
   logic [1:0]   key_level_unused;   // only press events drive the sequencer
   state_e       state, state_nxt;
   logic [W-1:0] reg_1_nxt, reg_2_nxt, ind_nxt;
   logic         pulse_nxt;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_a (
      .clk    (clk),
      .rst    (rst),
      .key_n  (key[0]),
      .stable (key_level_unused[0]),
      .press  (key_press[0])
   );

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_b (
      .clk    (clk),
      .rst    (rst),
      .key_n  (key[1]),
      .stable (key_level_unused[1]),
      .press  (key_press[1])
   );

   assign operand = ~num_s2;

   always_comb begin
      state_nxt = state;
      reg_1_nxt = reg_1;
      reg_2_nxt = reg_2;
      ind_nxt   = ind;
      pulse_nxt = 1'b0;
      case (key_press)
         2'b11: begin
            state_nxt = EMPTY;
            reg_1_nxt = '0;
            reg_2_nxt = '0;
            ind_nxt   = '0;
         end
         2'b01: begin
            reg_1_nxt = operand;
            ind_nxt   = operand;
            pulse_nxt = 1'b1;
            if (state == EMPTY)       state_nxt = HAVE_A;
            else if (state == HAVE_B) state_nxt = READY;
         end
         2'b10: begin
            reg_2_nxt = operand;
            ind_nxt   = operand;
            pulse_nxt = 1'b1;
            if (state == EMPTY)       state_nxt = HAVE_B;
            else if (state == HAVE_A) state_nxt = READY;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         num_s1         <= '1;
         num_s2         <= '1;
         state          <= EMPTY;
         reg_1          <= '0;
         reg_2          <= '0;
         ind            <= '0;
         led            <= LED_EMPTY;
         operands_valid <= 1'b0;
         load_pulse     <= 1'b0;
      end else begin
         num_s1         <= in_number;
         num_s2         <= num_s1;
         state          <= state_nxt;
         reg_1          <= reg_1_nxt;
         reg_2          <= reg_2_nxt;
         ind            <= ind_nxt;
         led            <= state_led(state_nxt);
         operands_valid <= (state_nxt == READY);
         load_pulse     <= pulse_nxt;
      end
   end

endmodule

// File: tb/tb_operand_entry.sv
// Self-checking bench for operand_entry: directed latency/table/corner sequences
// plus randomized key and switch activity compared against a cycle-level reference model.
module tb_operand_entry;

   localparam int unsigned W  = 4;
   localparam int unsigned DC = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] in_number;
   logic [1:0]   key;
   logic [W-1:0] reg_1, reg_2, ind;
   logic [2:0]   led;
   logic         operands_valid, load_pulse;

   operand_entry #(.W(W), .DEBOUNCE_CYCLES(DC)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_number      (in_number),
      .key            (key),
      .reg_1          (reg_1),
      .reg_2          (reg_2),
      .ind            (ind),
      .led            (led),
      .operands_valid (operands_valid),
      .load_pulse     (load_pulse)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit auto_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: raw inputs delayed two edges, a key level is accepted after
   // DC consecutive disagreeing cycles, and a 1->0 acceptance is acted on one edge later.
   logic [1:0]   m_key_hist[$];
   logic [W-1:0] m_num_hist[$];
   logic [1:0]   m_stable, m_pend, m_lvl;
   int           m_run[2];
   bit           m_ha, m_hb, m_lp;
   logic [W-1:0] m_r1, m_r2, m_ind, m_opnd;

   always @(posedge clk) begin
      if (rst) begin
         m_key_hist = {};
         m_num_hist = {};
         repeat (2) begin
            m_key_hist.push_back(2'b11);
            m_num_hist.push_back({W{1'b1}});
         end
         m_stable = 2'b11;
         m_pend   = 2'b00;
         m_run[0] = 0;
         m_run[1] = 0;
         m_ha = 0; m_hb = 0; m_lp = 0;
         m_r1 = '0; m_r2 = '0; m_ind = '0;
      end else begin
         m_lvl  = m_key_hist.pop_front();
         m_opnd = ~m_num_hist.pop_front();
         m_key_hist.push_back(key);
         m_num_hist.push_back(in_number);
         m_lp = 0;
         if (m_pend == 2'b11) begin
            m_ha = 0; m_hb = 0;
            m_r1 = '0; m_r2 = '0; m_ind = '0;
         end else if (m_pend[0]) begin
            m_ha = 1; m_r1 = m_opnd; m_ind = m_opnd; m_lp = 1;
         end else if (m_pend[1]) begin
            m_hb = 1; m_r2 = m_opnd; m_ind = m_opnd; m_lp = 1;
         end
         m_pend = 2'b00;
         for (int k = 0; k < 2; k++) begin
            if (m_lvl[k] == m_stable[k]) begin
               m_run[k] = 0;
            end else begin
               m_run[k]++;
               if (m_run[k] == DC) begin
                  m_stable[k] = m_lvl[k];
                  m_run[k]    = 0;
                  if (m_lvl[k] == 1'b0) m_pend[k] = 1'b1;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (auto_en) begin
         chk("model_reg_1", 32'(reg_1), 32'(m_r1));
         chk("model_reg_2", 32'(reg_2), 32'(m_r2));
         chk("model_ind", 32'(ind), 32'(m_ind));
         chk("model_led", 32'(led), 32'({~m_hb, ~m_ha, m_ha | m_hb}));
         chk("model_valid", 32'(operands_valid), 32'(m_ha & m_hb));
         chk("model_load_pulse", 32'(load_pulse), 32'(m_lp));
      end
   end

   task automatic hold(input int n, output int pulses);
      pulses = 0;
      repeat (n) begin
         @(negedge clk);
         if (load_pulse) pulses++;
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_reg_1"}, 32'(reg_1), 32'h0);
      chk({tag, "_reg_2"}, 32'(reg_2), 32'h0);
      chk({tag, "_ind"}, 32'(ind), 32'h0);
      chk({tag, "_led"}, 32'(led), 32'b110);
      chk({tag, "_valid"}, 32'(operands_valid), 32'h0);
      chk({tag, "_load_pulse"}, 32'(load_pulse), 32'h0);
   endtask

   typedef struct {
      logic [W-1:0] sw;
      logic [1:0]   keys;
      logic [W-1:0] r1, r2, ind;
      logic [2:0]   led;
      logic         valid;
      int           pulses;
   } vec_t;

   vec_t tbl[9];

   initial begin
      int p, p2;
      tbl[0] = '{4'b0000, 2'b10, 4'hF, 4'hC, 4'hF, 3'b001, 1'b1, 1};  // overwrite A in READY
      tbl[1] = '{4'b1111, 2'b01, 4'hF, 4'h0, 4'h0, 3'b001, 1'b1, 1};  // overwrite B in READY
      tbl[2] = '{4'b0101, 2'b00, 4'h0, 4'h0, 4'h0, 3'b110, 1'b0, 0};  // simultaneous -> clear
      tbl[3] = '{4'b0110, 2'b01, 4'h0, 4'h9, 4'h9, 3'b011, 1'b0, 1};  // B from EMPTY
      tbl[4] = '{4'b1110, 2'b10, 4'h1, 4'h9, 4'h1, 3'b001, 1'b1, 1};  // A from HAVE_B
      tbl[5] = '{4'b0000, 2'b11, 4'h1, 4'h9, 4'h1, 3'b001, 1'b1, 0};  // switches only
      tbl[6] = '{4'b1001, 2'b00, 4'h0, 4'h0, 4'h0, 3'b110, 1'b0, 0};  // clear again
      tbl[7] = '{4'b0011, 2'b10, 4'hC, 4'h0, 4'hC, 3'b101, 1'b0, 1};  // A from EMPTY
      tbl[8] = '{4'b1100, 2'b10, 4'h3, 4'h0, 4'h3, 3'b101, 1'b0, 1};  // overwrite in HAVE_A

      rst = 1'b1;
      key = 2'b11;
      in_number = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_reset_state("reset");
      rst = 1'b0;
      auto_en = 1'b1;
      hold(12, p);

      // Load A: exact latency of 2 + DC + 1 edges after the key edge
      in_number = 4'b1010;
      key = 2'b10;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k < 7) begin
            chk("lat_a_quiet_pulse", 32'(load_pulse), 32'h0);
            chk("lat_a_quiet_reg_1", 32'(reg_1), 32'h0);
         end else if (k == 7) begin
            chk("lat_a_pulse", 32'(load_pulse), 32'h1);
            chk("lat_a_reg_1", 32'(reg_1), 32'h5);
            chk("lat_a_ind", 32'(ind), 32'h5);
            chk("lat_a_led", 32'(led), 32'b101);
         end else begin
            chk("lat_a_pulse_end", 32'(load_pulse), 32'h0);
         end
      end
      hold(2, p);
      key = 2'b11;
      hold(12, p);
      chk("release_a_no_pulse", 32'(p), 32'h0);

      // Load B -> READY
      in_number = 4'b0011;
      key = 2'b01;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k < 7) begin
            chk("lat_b_quiet_pulse", 32'(load_pulse), 32'h0);
         end else if (k == 7) begin
            chk("lat_b_pulse", 32'(load_pulse), 32'h1);
            chk("lat_b_reg_2", 32'(reg_2), 32'hC);
            chk("lat_b_ind", 32'(ind), 32'hC);
            chk("lat_b_led", 32'(led), 32'b001);
            chk("lat_b_valid", 32'(operands_valid), 32'h1);
         end else begin
            chk("lat_b_pulse_end", 32'(load_pulse), 32'h0);
         end
      end
      hold(2, p);
      key = 2'b11;
      hold(12, p);

      foreach (tbl[i]) begin
         in_number = tbl[i].sw;
         key = tbl[i].keys;
         hold(10, p);
         key = 2'b11;
         hold(12, p2);
         chk($sformatf("tbl%0d_pulses", i), 32'(p + p2), 32'(tbl[i].pulses));
         chk($sformatf("tbl%0d_reg_1", i), 32'(reg_1), 32'(tbl[i].r1));
         chk($sformatf("tbl%0d_reg_2", i), 32'(reg_2), 32'(tbl[i].r2));
         chk($sformatf("tbl%0d_ind", i), 32'(ind), 32'(tbl[i].ind));
         chk($sformatf("tbl%0d_led", i), 32'(led), 32'(tbl[i].led));
         chk($sformatf("tbl%0d_valid", i), 32'(operands_valid), 32'(tbl[i].valid));
      end

      // Bounce shorter than the debounce window: no load, state kept
      p2 = 0;
      for (int i = 0; i < 5; i++) begin
         in_number = 4'(i);
         key = 2'b10;
         hold(2, p);
         p2 += p;
         key = 2'b11;
         hold(2, p);
         p2 += p;
      end
      hold(12, p);
      chk("bounce_pulses", 32'(p + p2), 32'h0);
      chk("bounce_reg_1", 32'(reg_1), 32'h3);
      chk("bounce_led", 32'(led), 32'b101);

      // Reset in the middle of a debounce; key stays held afterwards
      in_number = 4'b0001;
      key = 2'b10;
      hold(3, p);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk_reset_state("midrst");
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k == 7) begin
            chk("midrst_pulse", 32'(load_pulse), 32'h1);
            chk("midrst_reg_1", 32'(reg_1), 32'hE);
            chk("midrst_led", 32'(led), 32'b101);
         end else begin
            chk("midrst_no_pulse", 32'(load_pulse), 32'h0);
         end
      end
      key = 2'b11;
      hold(12, p);

      // Randomized activity, checked every cycle by the model
      for (int i = 0; i < 400; i++) begin
         key = 2'($urandom);
         in_number = 4'($urandom);
         if ($urandom_range(0, 39) == 0) rst = 1'b1;
         hold(1, p);
         rst = 1'b0;
         hold(int'($urandom_range(0, 8)), p);
      end
      key = 2'b11;
      hold(12, p);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
